// File: rtl/pe_operand_join.sv
// ---------------------------------------------------------------------------
// pe_operand_join: joins three buffered operand streams into one credit-gated
// MAC issue beat. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pe_operand_join #(
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS    = 16,
  parameter int CNT_W      = 32
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       s_axis_a_tvalid,
  output logic                       s_axis_a_tready,
  input  logic [31:0]                s_axis_a_tdata,
  input  logic                       s_axis_b_tvalid,
  output logic                       s_axis_b_tready,
  input  logic [31:0]                s_axis_b_tdata,
  input  logic                       s_axis_c_tvalid,
  output logic                       s_axis_c_tready,
  input  logic [31:0]                s_axis_c_tdata,
  input  logic [7:0]                 cfg_op,
  input  logic                       credit_return,
  output logic                       m_axis_a_tvalid,
  output logic                       m_axis_b_tvalid,
  output logic                       m_axis_c_tvalid,
  output logic                       m_axis_operation_tvalid,
  output logic [31:0]                m_axis_a_tdata,
  output logic [31:0]                m_axis_b_tdata,
  output logic [31:0]                m_axis_c_tdata,
  output logic [7:0]                 m_axis_operation_tdata,
  output logic [CNT_W-1:0]           issue_count,
  output logic [$clog2(CREDITS):0]   credit_avail,
  output logic                       err_credit_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CREDITS) + 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [2:0]  fifo_nempty;
  logic [31:0] in_data [3];
  logic [31:0] head    [3];
  logic        issue;

  assign in_valid   = {s_axis_c_tvalid, s_axis_b_tvalid, s_axis_a_tvalid};
  assign in_data[0] = s_axis_a_tdata;
  assign in_data[1] = s_axis_b_tdata;
  assign in_data[2] = s_axis_c_tdata;

  assign s_axis_a_tready = in_ready[0];
  assign s_axis_b_tready = in_ready[1];
  assign s_axis_c_tready = in_ready[2];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  for (genvar g = 0; g < 3; g++) begin : g_fifo
    logic [31:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        full;
    logic        push;

    assign full           = (wptr_q[AW] != rptr_q[AW]) &&
                            (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign in_ready[g]    = ~full;
    assign fifo_nempty[g] = (wptr_q != rptr_q);
    assign push           = in_valid[g] & ~full;
    assign wptr_d         = push  ? wptr_q + 1'b1 : wptr_q;
    assign rptr_d         = issue ? rptr_q + 1'b1 : rptr_q;
    assign head[g]        = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
      end
    end

    always_ff @(posedge aclk) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= in_data[g];
    end
  end

  logic [CW-1:0]    credit_q, credit_d;
  logic             ovf_q, ovf_d;
  logic             valid_q;
  logic [31:0]      a_q, a_d, b_q, b_d, c_q, c_d;
  logic [7:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign issue = (&fifo_nempty) && (credit_q != '0);

  always_comb begin
    credit_d = credit_q;
    ovf_d    = ovf_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    if (issue && !credit_return) begin
      credit_d = credit_q - 1'b1;
    end else if (!issue && credit_return) begin
      // A return with nothing outstanding is a downstream protocol error.
      if (credit_q == CREDIT_MAX) ovf_d = 1'b1;
      else                        credit_d = credit_q + 1'b1;
    end
    if (issue) begin
      a_d   = head[0];
      b_d   = head[1];
      c_d   = head[2];
      op_d  = cfg_op;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      credit_q <= CREDIT_MAX;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
    end else begin
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
      valid_q  <= issue;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
    end
  end

  assign m_axis_a_tvalid         = valid_q;
  assign m_axis_b_tvalid         = valid_q;
  assign m_axis_c_tvalid         = valid_q;
  assign m_axis_operation_tvalid = valid_q;
  assign m_axis_a_tdata          = a_q;
  assign m_axis_b_tdata          = b_q;
  assign m_axis_c_tdata          = c_q;
  assign m_axis_operation_tdata  = op_q;
  assign issue_count             = cnt_q;
  assign credit_avail            = credit_q;
  assign err_credit_ovf          = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_pe_operand_join.sv
// ---------------------------------------------------------------------------
// tb_pe_operand_join: directed stimulus with a queue scoreboard and an
// independent output monitor. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pe_operand_join;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        a_vld = 1'b0, b_vld = 1'b0, c_vld = 1'b0;
  logic        a_rdy, b_rdy, c_rdy;
  logic [31:0] a_dat = '0, b_dat = '0, c_dat = '0;
  logic [7:0]  cfg_op = '0;
  logic        credit_return = 1'b0;
  logic        m_a_v, m_b_v, m_c_v, m_op_v;
  logic [31:0] m_a, m_b, m_c;
  logic [7:0]  m_op;
  logic [31:0] issue_count;
  logic [4:0]  credit_avail;
  logic        err_ovf;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [7:0]  op;
  } beat_t;

  beat_t sb[$];
  beat_t mon_e;
  int    n_checks = 0;
  int    n_errors = 0;
  int    pulse_cnt = 0;
  int    exp_issue = 0;
  int    p0;

  pe_operand_join #(.FIFO_DEPTH(4), .CREDITS(16), .CNT_W(32)) dut (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .s_axis_a_tvalid        (a_vld),
    .s_axis_a_tready        (a_rdy),
    .s_axis_a_tdata         (a_dat),
    .s_axis_b_tvalid        (b_vld),
    .s_axis_b_tready        (b_rdy),
    .s_axis_b_tdata         (b_dat),
    .s_axis_c_tvalid        (c_vld),
    .s_axis_c_tready        (c_rdy),
    .s_axis_c_tdata         (c_dat),
    .cfg_op                 (cfg_op),
    .credit_return          (credit_return),
    .m_axis_a_tvalid        (m_a_v),
    .m_axis_b_tvalid        (m_b_v),
    .m_axis_c_tvalid        (m_c_v),
    .m_axis_operation_tvalid(m_op_v),
    .m_axis_a_tdata         (m_a),
    .m_axis_b_tdata         (m_b),
    .m_axis_c_tdata         (m_c),
    .m_axis_operation_tdata (m_op),
    .issue_count            (issue_count),
    .credit_avail           (credit_avail),
    .err_credit_ovf         (err_ovf)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Output monitor: every issued beat must match the oldest expected beat.
  always @(negedge aclk) begin
    if (!aresetn) begin
      exp_issue = 0;
    end else if (m_a_v) begin
      pulse_cnt++;
      exp_issue++;
      chk("strobes_equal", {29'd0, m_b_v, m_c_v, m_op_v}, 32'h7);
      if (sb.size() == 0) begin
        chk("unexpected_beat", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("a_data", m_a, mon_e.a);
        chk("b_data", m_b, mon_e.b);
        chk("c_data", m_c, mon_e.c);
        chk("op_data", {24'd0, m_op}, {24'd0, mon_e.op});
      end
      chk("issue_count", issue_count, exp_issue);
    end
  end

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [7:0] op);
    beat_t e;
    e.a = a; e.b = b; e.c = c; e.op = op;
    sb.push_back(e);
  endtask

  task automatic stream_triple(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    int n = 0;
    a_vld = 1'b1; b_vld = 1'b1; c_vld = 1'b1;
    a_dat = a;    b_dat = b;    c_dat = c;
    while (!(a_rdy && b_rdy && c_rdy) && n < 200) begin
      @(posedge aclk); #1;
      n++;
    end
    if (n >= 200) chk("stream_timeout", 32'd1, 32'd0);
    @(posedge aclk); #1;
    a_vld = 1'b0; b_vld = 1'b0; c_vld = 1'b0;
  endtask

  task automatic ret_pulse();
    credit_return = 1'b1;
    @(posedge aclk); #1;
    credit_return = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(posedge aclk); #1;
      n++;
    end
    chk("drain_timeout", sb.size(), 32'd0);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_valid", {28'd0, m_a_v, m_b_v, m_c_v, m_op_v}, 32'h0);
    chk("rst_data_a", m_a, 32'h0);
    chk("rst_data_op", {24'd0, m_op}, 32'h0);
    chk("rst_issue_count", issue_count, 32'd0);
    chk("rst_credit", {27'd0, credit_avail}, 32'd16);
    chk("rst_ovf", {31'd0, err_ovf}, 32'd0);
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("rst_tready", {29'd0, c_rdy, b_rdy, a_rdy}, 32'h7);

    // Single beat: valid appears two edges after presentation
    cfg_op = 8'h00;
    push_exp(32'h3F800000, 32'h40000000, 32'h40400000, 8'h00);
    a_vld = 1'b1; b_vld = 1'b1; c_vld = 1'b1;
    a_dat = 32'h3F800000; b_dat = 32'h40000000; c_dat = 32'h40400000;
    @(posedge aclk); #1;
    a_vld = 1'b0; b_vld = 1'b0; c_vld = 1'b0;
    @(negedge aclk);
    chk("single_lat_cyc1", {31'd0, m_a_v}, 32'd0);
    @(negedge aclk);
    chk("single_lat_cyc2", {31'd0, m_a_v}, 32'd1);
    chk("single_credit", {27'd0, credit_avail}, 32'd15);
    @(negedge aclk);
    chk("single_one_pulse", {31'd0, m_a_v}, 32'd0);

    // Skewed arrival: a at 0, b at 3, c at 7 -> one pulse in cycle 9
    push_exp(32'h11111111, 32'h22222222, 32'h33333333, 8'h00);
    @(posedge aclk); #1;
    for (int k = 0; k < 12; k++) begin
      a_vld = (k == 0); a_dat = 32'h11111111;
      b_vld = (k == 3); b_dat = 32'h22222222;
      c_vld = (k == 7); c_dat = 32'h33333333;
      @(negedge aclk);
      chk($sformatf("skew_valid_cyc%0d", k), {31'd0, m_a_v}, {31'd0, (k == 9)});
      @(posedge aclk); #1;
    end
    chk("skew_credit", {27'd0, credit_avail}, 32'd14);

    // Credit exhaustion: 20 triples, only 16 issue until credits return
    ret_pulse();
    ret_pulse();
    chk("refill_credit", {27'd0, credit_avail}, 32'd16);
    cfg_op = 8'h01;
    p0 = pulse_cnt;
    for (int i = 0; i < 20; i++) begin
      push_exp(32'h100 + i, 32'h200 + i, 32'h300 + i, 8'h01);
      stream_triple(32'h100 + i, 32'h200 + i, 32'h300 + i);
    end
    repeat (8) @(posedge aclk);
    #1;
    chk("exhaust_pulses", pulse_cnt - p0, 32'd16);
    chk("exhaust_credit", {27'd0, credit_avail}, 32'd0);
    chk("exhaust_fifo_full", {31'd0, a_rdy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      ret_pulse();
      repeat (2) @(posedge aclk);
      #1;
      chk($sformatf("return_pulses_%0d", i), pulse_cnt - p0, 32'(17 + i));
    end
    wait_drain(50);
    chk("return_credit", {27'd0, credit_avail}, 32'd0);
    cfg_op = 8'h00;
    for (int i = 0; i < 16; i++) ret_pulse();
    chk("restore_credit", {27'd0, credit_avail}, 32'd16);

    // Backpressure: withhold c, a/b fill after four beats
    p0 = pulse_cnt;
    for (int i = 0; i < 4; i++) begin
      a_vld = 1'b1; a_dat = 32'hA0000000 + i;
      b_vld = 1'b1; b_dat = 32'hB0000000 + i;
      @(posedge aclk); #1;
    end
    a_dat = 32'hA0000004; b_dat = 32'hB0000004;
    chk("bp_ready_ab", {30'd0, a_rdy, b_rdy}, 32'h0);
    @(posedge aclk); #1;
    a_vld = 1'b0; b_vld = 1'b0;
    chk("bp_no_issue", pulse_cnt - p0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      push_exp(32'hA0000000 + i, 32'hB0000000 + i, 32'hC0000000 + i, 8'h00);
      c_vld = 1'b1; c_dat = 32'hC0000000 + i;
      @(posedge aclk); #1;
    end
    c_vld = 1'b0;
    wait_drain(50);
    chk("bp_pulses", pulse_cnt - p0, 32'd4);
    chk("bp_ready_back", {30'd0, a_rdy, b_rdy}, 32'h3);
    chk("bp_credit", {27'd0, credit_avail}, 32'd12);

    // Simultaneous issue and return at 5; overflow at 16
    for (int i = 0; i < 7; i++) begin
      push_exp(32'h500 + i, 32'h600 + i, 32'h700 + i, 8'h00);
      stream_triple(32'h500 + i, 32'h600 + i, 32'h700 + i);
    end
    wait_drain(50);
    chk("pre_simul_credit", {27'd0, credit_avail}, 32'd5);
    push_exp(32'h0000ABCD, 32'h0000BCDE, 32'h0000CDEF, 8'h00);
    a_vld = 1'b1; b_vld = 1'b1; c_vld = 1'b1;
    a_dat = 32'h0000ABCD; b_dat = 32'h0000BCDE; c_dat = 32'h0000CDEF;
    @(posedge aclk); #1;
    a_vld = 1'b0; b_vld = 1'b0; c_vld = 1'b0;
    ret_pulse();
    chk("simul_credit", {27'd0, credit_avail}, 32'd5);
    wait_drain(20);
    for (int i = 0; i < 11; i++) ret_pulse();
    chk("full_credit", {27'd0, credit_avail}, 32'd16);
    chk("ovf_clear", {31'd0, err_ovf}, 32'd0);
    ret_pulse();
    chk("ovf_credit", {27'd0, credit_avail}, 32'd16);
    chk("ovf_set", {31'd0, err_ovf}, 32'd1);
    repeat (3) @(posedge aclk);
    #1;
    chk("ovf_sticky", {31'd0, err_ovf}, 32'd1);

    // Reset mid-stream while a valid beat is on the output
    for (int i = 0; i < 4; i++) begin
      push_exp(32'h900 + i, 32'h910 + i, 32'h920 + i, 8'h00);
      stream_triple(32'h900 + i, 32'h910 + i, 32'h920 + i);
    end
    begin
      int n = 0;
      do begin
        @(negedge aclk);
        n++;
      end while (!m_a_v && n < 10);
      chk("rst_mid_saw_valid", {31'd0, m_a_v}, 32'd1);
    end
    #2 aresetn = 1'b0;
    #1;
    chk("rst_mid_valid_drop", {28'd0, m_a_v, m_b_v, m_c_v, m_op_v}, 32'h0);
    chk("rst_mid_data", m_b, 32'h0);
    sb.delete();
    repeat (2) @(posedge aclk);
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("post_rst_tready", {29'd0, c_rdy, b_rdy, a_rdy}, 32'h7);
    chk("post_rst_credit", {27'd0, credit_avail}, 32'd16);
    chk("post_rst_count", issue_count, 32'd0);
    chk("post_rst_ovf", {31'd0, err_ovf}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      chk("post_rst_fifo_empty", {31'd0, m_a_v}, 32'd0);
    end

    // Recovery beat after reset
    cfg_op = 8'h01;
    push_exp(32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 8'h01);
    @(posedge aclk); #1;
    stream_triple(32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678);
    wait_drain(20);
    chk("post_rst_issue_count", issue_count, 32'd1);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pe_operand_join.md
Name: pe_operand_join

Overview:
- Upstream issue stage for the floating-point MAC processing element.
- Buffers three independent operand streams (a, b, c) and joins them into one synchronous issue beat. All four MAC input channels (a, b, c, operation) are presented valid in the same cycle.
- The MAC has fixed latency and no backpressure. Flow control uses a credit counter sized to the downstream result buffer, so an issued result can never be dropped.

Parameters:
- FIFO_DEPTH, 4, entries per operand FIFO; power of two, ≥2.
- CREDITS, 16, initial/maximum credit count, equal to downstream result-buffer depth.
- CNT_W, 32, width of the issued-beat counter.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_a_tvalid  in  1  operand a valid.
- s_axis_a_tready  out  1  operand a ready.
- s_axis_a_tdata  in  32  operand a, IEEE-754 single.
- s_axis_b_tvalid / s_axis_b_tready / s_axis_b_tdata  in/out/in  1/1/32  operand b channel.
- s_axis_c_tvalid / s_axis_c_tready / s_axis_c_tdata  in/out/in  1/1/32  operand c channel.
- cfg_op  in  8  MAC operation code, sampled at issue (0x00 = a*b+c, 0x01 = a*b−c).
- credit_return  in  1  one-cycle pulse per result consumed downstream.
- m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid, m_axis_operation_tvalid  out  1 each  issue strobes, always identical.
- m_axis_a_tdata, m_axis_b_tdata, m_axis_c_tdata  out  32 each  issued operands.
- m_axis_operation_tdata  out  8  issued operation code.
- issue_count  out  CNT_W  total beats issued, wraps modulo 2^CNT_W.
- credit_avail  out  log2(CREDITS)+1  current credit count.
- err_credit_ovf  out  1  sticky: credit_return arrived while credits were already at CREDITS.

Behaviour:
- Clock and reset: one clock, aclk. Reset is aresetn, asynchronous assert, active-low; deassertion is synchronous to aclk.
- Reset values:
  - all m_*_tvalid = 0;
  - all m_*_tdata = 0;
  - issue_count = 0;
  - credit_avail = CREDITS;
  - err_credit_ovf = 0;
  - all FIFOs empty;
  - s_axis_*_tready = 1 from the first cycle after deassertion.
- Input handshake:
  - Each channel has its own FIFO.
  - tready = FIFO not full.
  - A write occurs on tvalid & tready at the rising edge.
  - tready never depends on tvalid.
  - A full FIFO with a simultaneous pop does NOT accept that cycle; tready is registered from occupancy.
- Issue condition (combinational in cycle N): all three FIFOs non-empty AND credit_avail > 0.
- When issue is true:
  - pop one entry from each FIFO;
  - at the end of N, register the heads and cfg_op into the m_* data registers;
  - all m_*_tvalid = 1 during cycle N+1, for exactly one cycle per issue.
  - Back-to-back issues give a continuous valid.
- When issue is false: m_*_tvalid = 0 next cycle; data registers hold their last value.
- Latency: input beat accepted at edge t → earliest output valid in cycle t+2 (FIFO write, then issue register).
- Throughput: one issue per cycle when all FIFOs are non-empty and credits are available.
- Ordering: strict FIFO per channel. The k-th a, k-th b and k-th c always issue together.
- Credits:
  - issue only: decrement by 1.
  - credit_return only: increment by 1.
  - both in the same cycle: unchanged.
  - credit_return while credit_avail == CREDITS and no issue: count stays at CREDITS, err_credit_ovf sets; it clears only on reset.
  - Credits never go below 0, because issue is blocked at 0.
- issue_count increments by 1 per issue and wraps from all-ones to 0.
- Reset mid-operation: FIFO contents are discarded, any in-progress m_* valid drops immediately (asynchronous), and credits restore to CREDITS. Results already inside the MAC are the downstream block's responsibility.
- No X propagation: FIFO storage need not be reset, but outputs must show reset values.

Test Plan:
- Single beat: a=0x3F800000, b=0x40000000, c=0x40400000, cfg_op=0x00, all presented at cycle 0 → one m valid pulse in cycle 2 with the same data and operation 0x00; issue_count=1; credit_avail=15.
- Skewed arrival: a at cycle 0, b at cycle 3, c at cycle 7 → no valid until cycle 9; exactly one pulse; a-FIFO occupancy is 1 during cycles 1–8.
- Credit exhaustion: CREDITS=16, 20 full triples streamed, no credit_return → exactly 16 consecutive valid cycles, then stall with credit_avail=0. Four credit_return pulses → remaining 4 issue in order, one per credit.
- Backpressure: withhold c while streaming a and b → s_axis_a_tready and s_axis_b_tready drop after 4 accepted beats. Release c → 4 issues pairing a0/b0/c0 … a3/b3/c3, then tready rises.
- Simultaneous issue and credit_return at credit_avail=5 → credit_avail stays 5. credit_return at 16 with no traffic → stays 16 and err_credit_ovf=1.
- Reset mid-stream: aresetn low while m valid is high → valid 0 the same cycle. After release: FIFOs empty, credit_avail=16, issue_count=0, tready=1.
